// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use interlock, redirect squash,
// memory-wait freeze with a watchdog, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read_ena,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              memstall;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;

  assign memstall = mem_req & ~mem_ready;
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_mem_read_ena & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and same-cycle stall/flush decode
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (!memstall) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = HALT;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    // Memory wait outranks redirect, which outranks the load-use bubble
    if (!reset) begin
      if (state_q == HALT || memstall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Sticky watchdog flag
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout_err <= 1'b0;
    end else if (state_d == HALT) begin
      mem_timeout_err <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_ex_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model; a narrow-counter instance covers saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read_ena, ex_redirect, mem_req, mem_ready;

  logic        d_pc, d_ifs, d_ids, d_exs, d_iff, d_idf, d_mwf, d_err;
  logic [31:0] d_sc, d_fc;
  logic        s_pc, s_ifs, s_ids, s_exs, s_iff, s_idf, s_mwf, s_err;
  logic [3:0]  s_sc, s_fc;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: halted flag, consecutive memstall run length, counters
  bit     m_halt;
  int     m_run;
  longint m_sc_d, m_fc_d, m_sc_s, m_fc_s;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut_d (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read_ena(ex_mem_read_ena), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(d_pc), .if_id_stall(d_ifs), .id_ex_stall(d_ids), .ex_mem_stall(d_exs),
    .if_id_flush(d_iff), .id_ex_flush(d_idf), .mem_wb_flush(d_mwf),
    .mem_timeout_err(d_err), .stall_cnt(d_sc), .flush_cnt(d_fc)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read_ena(ex_mem_read_ena), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(s_pc), .if_id_stall(s_ifs), .id_ex_stall(s_ids), .ex_mem_stall(s_exs),
    .if_id_flush(s_iff), .id_ex_flush(s_idf), .mem_wb_flush(s_mwf),
    .mem_timeout_err(s_err), .stall_cnt(s_sc), .flush_cnt(s_fc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic ld, input logic rdr, input logic rq, input logic rdy);
    logic [6:0] exp;
    logic [6:0] got_d, got_s;
    bit ms, lu;
    @(negedge clk);
    reset = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read_ena = ld; ex_redirect = rdr; mem_req = rq; mem_ready = rdy;
    #1;
    ms = rq && !rdy;
    lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, mem_wb flushes}
    if (r)                exp = 7'b0000_000;
    else if (m_halt || ms) exp = 7'b1111_001;
    else if (rdr)         exp = 7'b0000_110;
    else if (lu)          exp = 7'b1100_010;
    else                  exp = 7'b0000_000;
    got_d = {d_pc, d_ifs, d_ids, d_exs, d_iff, d_idf, d_mwf};
    got_s = {s_pc, s_ifs, s_ids, s_exs, s_iff, s_idf, s_mwf};
    chk("ctrl_outputs", 64'(got_d), 64'(exp));
    chk("ctrl_outputs_narrow", 64'(got_s), 64'(exp));
    chk("timeout_err", 64'(d_err), 64'(m_halt));
    chk("timeout_err_narrow", 64'(s_err), 64'(m_halt));
    chk("stall_cnt", 64'(d_sc), 64'(m_sc_d));
    chk("flush_cnt", 64'(d_fc), 64'(m_fc_d));
    chk("stall_cnt_sat", 64'(s_sc), 64'(m_sc_s));
    chk("flush_cnt_sat", 64'(s_fc), 64'(m_fc_s));
    if (r) begin
      m_halt = 0; m_run = 0;
      m_sc_d = 0; m_fc_d = 0; m_sc_s = 0; m_fc_s = 0;
    end else begin
      if (exp[6]) begin
        m_sc_d = sat_inc(m_sc_d, 64'hFFFF_FFFF);
        m_sc_s = sat_inc(m_sc_s, 15);
      end
      if (exp[1]) begin
        m_fc_d = sat_inc(m_fc_d, 64'hFFFF_FFFF);
        m_fc_s = sat_inc(m_fc_s, 15);
      end
      if (!m_halt) begin
        if (ms) begin
          m_run++;
          if (m_run >= int'(TO)) m_halt = 1;
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read_ena = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    m_halt = 0; m_run = 0; m_sc_d = 0; m_fc_d = 0; m_sc_s = 0; m_fc_s = 0;

    do_reset();
    idle(1);

    // Load-use on rs2, then the same pattern with ex_rd = 0
    cyc(0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0);
    idle(1);
    cyc(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    cyc(0, 5'd7, 5'd2, 1, 0, 5'd7, 1, 0, 0, 1);
    idle(1);

    // Redirect masks a simultaneous load-use
    cyc(0, 5'd9, 5'd3, 1, 1, 5'd9, 1, 1, 0, 0);
    idle(1);

    // Three-cycle memory wait, then release
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Redirect deferred across a two-cycle memory wait
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);

    // mem_ready in wait cycle 16 avoids HALT
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Watchdog fires, HALT ignores later traffic, reset recovers
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 5'd4, 5'd4, 1, 1, 5'd4, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    idle(1);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) cyc(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0);
    idle(2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, u1, u2, ld, rdr, rq, rdy;
      logic [4:0] rs1, rs2, rd;
      r   = ($urandom_range(0, 79) == 0);
      rs1 = 5'($urandom_range(0, 5));
      rs2 = 5'($urandom_range(0, 5));
      rd  = 5'($urandom_range(0, 5));
      u1  = 1'($urandom);
      u2  = 1'($urandom);
      ld  = 1'($urandom);
      rdr = ($urandom_range(0, 3) == 0);
      rq  = 1'($urandom);
      rdy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 1));
      cyc(r, rs1, rs2, u1, u2, rd, ld, rdr, rq, rdy);
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
